fifo_ctrl_32x8: RTL and testbench
=================================

# fifo_ctrl_32x8

Sequential controller that turns a synchronous push/pop FIFO interface into the raw access signals of the structural 32x8 RAM. The RAM is built from four 8x8 banks, each addressed by one-hot row selects and a shared write enable. The controller owns the write and read pointers, the occupancy count and the full/empty flags. It serialises every access because the RAM has a single row-select port. It sits directly upstream of the RAM: it drives the RAM's data input, row selects and write enable, and captures the RAM's data output.

## Interface
- DEPTH, 32: number of FIFO entries; equals the number of RAM rows.
- WIDTH, 8: data width.
- ADDR_W, 5: pointer width, log2(DEPTH).

- Clock  in  1  single system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Push  in  1  write request; accepted when Push && Push_Ready.
- Data_In  in  WIDTH  write data; sampled on the accept edge.
- Push_Ready  out  1  controller can accept a push this cycle.
- Pop  in  1  read request; accepted when Pop && Pop_Ready.
- Pop_Ready  out  1  controller can accept a pop this cycle.
- Data_Out  out  WIDTH  registered read data.
- Data_Valid  out  1  one-cycle pulse; Data_Out holds new data.
- Full  out  1  Count == DEPTH.
- Empty  out  1  Count == 0.
- Count  out  ADDR_W+1  current occupancy, 0..32.
- Ram_Input  out  WIDTH  data to the RAM Input bus.
- Ram_Output  in  WIDTH  data from the RAM Output bus.
- Row_Select  out  DEPTH  one-hot RAM row select; bits [8k+7:8k] go to bank k.
- Write_Enable  out  1  RAM write enable.

## Operation
- FSM states: IDLE, WRITE, READ. All are registered.
- Push_Ready = (state==IDLE) && !Full && !(Pop && !Empty) && !Reset.
- Pop_Ready = (state==IDLE) && !Empty && !Reset.
- Priority:
  - A pop beats a push in the same cycle.
  - The producer holds Push and Data_In until accepted.
- IDLE transitions:
  - Pop accepted → READ.
  - Else push accepted → WRITE; Data_In is latched into Ram_Input.
  - Else stay in IDLE.
- WRITE state:
  - Row_Select = onehot(wr_ptr), Write_Enable = 1.
  - On exit: wr_ptr += 1 (mod 32), Count += 1, then → IDLE.
- READ state:
  - Row_Select = onehot(rd_ptr), Write_Enable = 0.
  - Data_Out <= Ram_Output on the edge that leaves READ.
  - On exit: Data_Valid = 1 for the next cycle, rd_ptr += 1 (mod 32), Count -= 1, then → IDLE.
- IDLE outputs: Row_Select = 0 and Write_Enable = 0, so no row drives the RAM Output bus.
- Pointers wrap naturally: 31 → 0. Count never exceeds 32 and never goes below 0, because the ready gating guarantees it.
- Full and Empty are derived from the registered Count, so they change on the cycle after WRITE or READ ends.
- Data_Out holds its last value until the next READ completes.

## Timing
- Reset values, applied on the first edge with Reset=1:
  - state = IDLE; wr_ptr = rd_ptr = 0; Count = 0.
  - Empty = 1, Full = 0.
  - Data_Out = 0, Data_Valid = 0.
  - Row_Select = 0, Write_Enable = 0, Ram_Input = 0.
  - Push_Ready and Pop_Ready are 0 while Reset=1.
- Push accepted at edge N:
  - WRITE is active in cycle N+1.
  - Count is updated and Push_Ready is high again in cycle N+2.
- Pop accepted at edge N:
  - READ is active in cycle N+1.
  - Data_Out is valid and Data_Valid = 1 in cycle N+2.
- Throughput: at most one access per 2 cycles.
- Reset during WRITE or READ: the operation is abandoned and no pointer or Count update occurs. RAM contents are not cleared; they are logically discarded.

## Test plan
- Reset held 2 cycles → Empty=1, Full=0, Count=0, Row_Select=0, Write_Enable=0, Data_Out=0, both Ready=0 during reset and Push_Ready=1 after.
- Push 0xA5 from empty → next cycle Row_Select=32'h0000_0001, Write_Enable=1, Ram_Input=0xA5; cycle after that, Count=1 and Empty=0.
- 32 pushes of 0x00..0x1F → Full=1, Count=32, Push_Ready=0; a 33rd push is held unaccepted and Count stays 32.
- Pop from full → READ cycle has Row_Select=onehot(0) and Write_Enable=0; Data_Out=0x00 with a one-cycle Data_Valid two cycles after accept. Draining all entries returns 0x00..0x1F in order and ends with Empty=1.
- Wrap-around: 40 alternating push/pop operations → Row_Select walks bit31 then bit0, and data order is preserved.
- Simultaneous Push and Pop at Count=5 → pop accepted and Push_Ready=0; push accepted at the next IDLE, leaving Count=5. Separately, assert Reset during a WRITE cycle → Count=0, wr_ptr=0, Empty=1 on the next cycle.

Source files
------------

// File: rtl/fifo_ctrl_32x8.sv
// Push/pop FIFO controller for the 32x8 four-bank RAM.
// Every access is serialised through one WRITE or READ cycle.
module fifo_ctrl_32x8 #(
    parameter int DEPTH  = 32,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 5
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Push,
    input  logic [WIDTH-1:0]  Data_In,
    output logic              Push_Ready,
    input  logic              Pop,
    output logic              Pop_Ready,
    output logic [WIDTH-1:0]  Data_Out,
    output logic              Data_Valid,
    output logic              Full,
    output logic              Empty,
    output logic [ADDR_W:0]   Count,
    output logic [WIDTH-1:0]  Ram_Input,
    input  logic [WIDTH-1:0]  Ram_Output,
    output logic [DEPTH-1:0]  Row_Select,
    output logic              Write_Enable
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ
    } state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_acc;
    logic              pop_acc;

    assign Full  = (Count == CNT_FULL);
    assign Empty = (Count == '0);

    // A pending pop masks push readiness so a pop always wins.
    assign Pop_Ready  = (state == IDLE) && !Empty && !Reset;
    assign Push_Ready = (state == IDLE) && !Full
                        && !(Pop && !Empty) && !Reset;

    assign pop_acc  = Pop && Pop_Ready;
    assign push_acc = Push && Push_Ready;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (pop_acc) begin
                    state_nxt = READ;
                end else if (push_acc) begin
                    state_nxt = WRITE;
                end
            end
            WRITE:   state_nxt = IDLE;
            READ:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Row_Select   = '0;
        Write_Enable = 1'b0;
        unique case (state)
            WRITE: begin
                Row_Select[wr_ptr] = 1'b1;
                Write_Enable       = 1'b1;
            end
            READ: begin
                Row_Select[rd_ptr] = 1'b1;
            end
            default: begin
                Row_Select   = '0;
                Write_Enable = 1'b0;
            end
        endcase
    end

    // Pointer and count updates happen only on the edge leaving an access.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            Count      <= '0;
            Ram_Input  <= '0;
            Data_Out   <= '0;
            Data_Valid <= 1'b0;
        end else begin
            Data_Valid <= (state == READ);
            if (push_acc) begin
                Ram_Input <= Data_In;
            end
            if (state == WRITE) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                Count  <= Count + CNT_ONE;
            end
            if (state == READ) begin
                Data_Out <= Ram_Output;
                rd_ptr   <= rd_ptr + PTR_ONE;
                Count    <= Count - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ctrl_32x8.sv
// Bench for fifo_ctrl_32x8 with a behavioural 32x8 RAM.
// Vector table plus hand sequences; read data checked via a queue.
module tb_fifo_ctrl_32x8;

    logic        Clock;
    logic        Reset;
    logic        Push;
    logic [7:0]  Data_In;
    logic        Push_Ready;
    logic        Pop;
    logic        Pop_Ready;
    logic [7:0]  Data_Out;
    logic        Data_Valid;
    logic        Full;
    logic        Empty;
    logic [5:0]  Count;
    logic [7:0]  Ram_Input;
    logic [7:0]  Ram_Output;
    logic [31:0] Row_Select;
    logic        Write_Enable;

    fifo_ctrl_32x8 dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Push         (Push),
        .Data_In      (Data_In),
        .Push_Ready   (Push_Ready),
        .Pop          (Pop),
        .Pop_Ready    (Pop_Ready),
        .Data_Out     (Data_Out),
        .Data_Valid   (Data_Valid),
        .Full         (Full),
        .Empty        (Empty),
        .Count        (Count),
        .Ram_Input    (Ram_Input),
        .Ram_Output   (Ram_Output),
        .Row_Select   (Row_Select),
        .Write_Enable (Write_Enable)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Behavioural RAM: rows not selected do not drive the output bus.
    logic [7:0] mem [32];

    always @(posedge Clock) begin
        if (Write_Enable) begin
            for (int i = 0; i < 32; i++) begin
                if (Row_Select[i]) mem[i] <= Ram_Input;
            end
        end
    end

    always_comb begin
        Ram_Output = '0;
        for (int i = 0; i < 32; i++) begin
            if (Row_Select[i]) Ram_Output = Ram_Output | mem[i];
        end
    end

    int checks;
    int errors;
    int exp_wr;
    int exp_rd;
    int exp_dv;
    int rcv_dv;
    logic prev_dv;
    logic [7:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Read-data scoreboard: every Data_Valid pulse pops one entry.
    always @(negedge Clock) begin
        if (Data_Valid === 1'b1) begin
            rcv_dv++;
            chk("dv_single_pulse", {31'd0, prev_dv}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %0h expected none",
                         Data_Out);
            end else begin
                chk("rd_data", {24'd0, Data_Out}, {24'd0, sb.pop_front()});
            end
        end
        prev_dv = Data_Valid;
    end

    task automatic wait_push(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (Push_Ready) begin
                ok = 1'b1;
                return;
            end
            @(negedge Clock);
        end
    endtask

    task automatic wait_pop(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (Pop_Ready) begin
                ok = 1'b1;
                return;
            end
            @(negedge Clock);
        end
    endtask

    task automatic push_one(input logic [7:0] d);
        bit ok;
        @(negedge Clock);
        Push = 1'b1;
        Data_In = d;
        wait_push(ok);
        if (!ok) begin
            chk("push_timeout", 32'd0, 32'd1);
            Push = 1'b0;
            return;
        end
        sb.push_back(d);
        @(negedge Clock);
        Push = 1'b0;
        chk("wr_row", Row_Select, 32'd1 << exp_wr);
        chk("wr_we", {31'd0, Write_Enable}, 32'd1);
        chk("wr_data", {24'd0, Ram_Input}, {24'd0, d});
        exp_wr = (exp_wr + 1) % 32;
    endtask

    task automatic pop_one();
        bit ok;
        @(negedge Clock);
        Pop = 1'b1;
        wait_pop(ok);
        if (!ok) begin
            chk("pop_timeout", 32'd0, 32'd1);
            Pop = 1'b0;
            return;
        end
        exp_dv++;
        @(negedge Clock);
        Pop = 1'b0;
        chk("rd_row", Row_Select, 32'd1 << exp_rd);
        chk("rd_we", {31'd0, Write_Enable}, 32'd0);
        exp_rd = (exp_rd + 1) % 32;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        Push = 1'b0;
        Pop = 1'b0;
        sb.delete();
        exp_wr = 0;
        exp_rd = 0;
        @(posedge Clock);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    typedef struct {
        logic        push;
        logic        pop;
        logic [7:0]  din;
        logic        pr;
        logic        ppr;
        logic        we;
        logic [31:0] rs;
        logic [5:0]  cnt;
        logic        empty;
        logic        dv;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;

        //         push pop din   pr ppr we rs cnt emp dv
        tbl[0]  = '{1, 0, 8'hA5, 1, 0, 1, 32'h1, 6'd0, 1, 0};
        tbl[1]  = '{0, 0, 8'h00, 0, 0, 0, 32'h0, 6'd1, 0, 0};
        tbl[2]  = '{1, 0, 8'h3C, 1, 1, 1, 32'h2, 6'd1, 0, 0};
        tbl[3]  = '{0, 0, 8'h00, 0, 0, 0, 32'h0, 6'd2, 0, 0};
        tbl[4]  = '{0, 1, 8'h00, 0, 1, 0, 32'h1, 6'd2, 0, 0};
        tbl[5]  = '{1, 1, 8'h77, 0, 0, 0, 32'h0, 6'd1, 0, 1};
        tbl[6]  = '{1, 1, 8'h77, 0, 1, 0, 32'h2, 6'd1, 0, 0};
        tbl[7]  = '{1, 0, 8'h77, 0, 0, 0, 32'h0, 6'd0, 1, 1};
        tbl[8]  = '{1, 0, 8'h77, 1, 0, 1, 32'h4, 6'd0, 1, 0};
        tbl[9]  = '{0, 0, 8'h00, 0, 0, 0, 32'h0, 6'd1, 0, 0};
        tbl[10] = '{0, 1, 8'h00, 0, 1, 0, 32'h4, 6'd1, 0, 0};
        tbl[11] = '{0, 0, 8'h00, 0, 0, 0, 32'h0, 6'd0, 1, 1};

        checks = 0;
        errors = 0;
        exp_wr = 0;
        exp_rd = 0;
        exp_dv = 0;
        rcv_dv = 0;
        prev_dv = 1'b0;
        Reset = 1'b1;
        Push = 1'b1;
        Pop = 1'b0;
        Data_In = 8'h11;

        // Reset with a push request held: nothing may be accepted.
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        chk("rst_push_ready", {31'd0, Push_Ready}, 32'd0);
        chk("rst_pop_ready", {31'd0, Pop_Ready}, 32'd0);
        chk("rst_empty", {31'd0, Empty}, 32'd1);
        chk("rst_full", {31'd0, Full}, 32'd0);
        chk("rst_count", {26'd0, Count}, 32'd0);
        chk("rst_row", Row_Select, 32'd0);
        chk("rst_we", {31'd0, Write_Enable}, 32'd0);
        chk("rst_dout", {24'd0, Data_Out}, 32'd0);
        chk("rst_dv", {31'd0, Data_Valid}, 32'd0);
        chk("rst_ram_in", {24'd0, Ram_Input}, 32'd0);
        Push = 1'b0;
        Reset = 1'b0;
        #1;
        chk("post_rst_push_ready", {31'd0, Push_Ready}, 32'd1);

        // Cycle-by-cycle vector table from empty.
        for (int i = 0; i < 12; i++) begin
            @(negedge Clock);
            Push = tbl[i].push;
            Pop = tbl[i].pop;
            Data_In = tbl[i].din;
            #1;
            chk($sformatf("v%0d_push_ready", i),
                {31'd0, Push_Ready}, {31'd0, tbl[i].pr});
            chk($sformatf("v%0d_pop_ready", i),
                {31'd0, Pop_Ready}, {31'd0, tbl[i].ppr});
            if (Push && Push_Ready) sb.push_back(Data_In);
            if (Pop && Pop_Ready) exp_dv++;
            @(posedge Clock);
            #1;
            chk($sformatf("v%0d_we", i),
                {31'd0, Write_Enable}, {31'd0, tbl[i].we});
            chk($sformatf("v%0d_row", i), Row_Select, tbl[i].rs);
            chk($sformatf("v%0d_count", i),
                {26'd0, Count}, {26'd0, tbl[i].cnt});
            chk($sformatf("v%0d_empty", i),
                {31'd0, Empty}, {31'd0, tbl[i].empty});
            chk($sformatf("v%0d_dv", i),
                {31'd0, Data_Valid}, {31'd0, tbl[i].dv});
            if (tbl[i].we) begin
                chk($sformatf("v%0d_ram_in", i),
                    {24'd0, Ram_Input}, {24'd0, tbl[i].din});
            end
        end
        Push = 1'b0;
        Pop = 1'b0;
        repeat (3) @(negedge Clock);
        chk("dout_hold", {24'd0, Data_Out}, 32'h77);

        // Fill to full, then hold a 33rd push.
        do_reset();
        for (int d = 0; d < 32; d++) push_one(8'(d));
        @(negedge Clock);
        Push = 1'b1;
        Data_In = 8'hEE;
        #1;
        chk("full_flag", {31'd0, Full}, 32'd1);
        chk("full_count", {26'd0, Count}, 32'd32);
        chk("full_push_ready", {31'd0, Push_Ready}, 32'd0);
        chk("full_pop_ready", {31'd0, Pop_Ready}, 32'd1);
        repeat (5) @(negedge Clock);
        chk("full_held_count", {26'd0, Count}, 32'd32);
        chk("full_held_we", {31'd0, Write_Enable}, 32'd0);
        Push = 1'b0;

        // Drain in order.
        for (int d = 0; d < 32; d++) pop_one();
        repeat (2) @(negedge Clock);
        chk("drain_empty", {31'd0, Empty}, 32'd1);
        chk("drain_count", {26'd0, Count}, 32'd0);
        chk("drain_sb", sb.size(), 32'd0);

        // Alternating push/pop walks both pointers across 31 -> 0.
        for (int k = 0; k < 40; k++) begin
            push_one(8'(k + 8'h40));
            pop_one();
        end
        repeat (2) @(negedge Clock);
        chk("wrap_sb", sb.size(), 32'd0);
        chk("wrap_empty", {31'd0, Empty}, 32'd1);

        // Simultaneous push and pop at Count=5.
        do_reset();
        for (int d = 0; d < 5; d++) push_one(8'(8'h10 + d));
        @(negedge Clock);
        Push = 1'b1;
        Pop = 1'b1;
        Data_In = 8'h55;
        #1;
        chk("both_pop_ready", {31'd0, Pop_Ready}, 32'd1);
        chk("both_push_ready", {31'd0, Push_Ready}, 32'd0);
        exp_dv++;
        @(negedge Clock);
        Pop = 1'b0;
        chk("both_rd_we", {31'd0, Write_Enable}, 32'd0);
        chk("both_rd_row", Row_Select, 32'd1 << exp_rd);
        exp_rd = (exp_rd + 1) % 32;
        wait_push(ok);
        if (!ok) begin
            chk("both_push_timeout", 32'd0, 32'd1);
        end else begin
            sb.push_back(8'h55);
            @(negedge Clock);
            chk("both_wr_row", Row_Select, 32'd1 << exp_wr);
            exp_wr = (exp_wr + 1) % 32;
        end
        Push = 1'b0;
        @(negedge Clock);
        chk("both_count", {26'd0, Count}, 32'd5);

        // Reset in the middle of a WRITE abandons it.
        @(negedge Clock);
        Push = 1'b1;
        Data_In = 8'h99;
        wait_push(ok);
        chk("rstwr_accept", {31'd0, ok}, 32'd1);
        @(negedge Clock);
        Push = 1'b0;
        chk("rstwr_in_write", {31'd0, Write_Enable}, 32'd1);
        Reset = 1'b1;
        sb.delete();
        exp_wr = 0;
        exp_rd = 0;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        chk("rstwr_count", {26'd0, Count}, 32'd0);
        chk("rstwr_empty", {31'd0, Empty}, 32'd1);
        chk("rstwr_we", {31'd0, Write_Enable}, 32'd0);
        push_one(8'hC3);
        pop_one();

        repeat (3) @(negedge Clock);
        chk("dv_total", rcv_dv, exp_dv);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
